// File: rtl/io_map_sync.sv
// io_map_sync: per-pin pad mapper (GPIO / MIPI SCLK,SDA / freq counter) with synchronised
// inputs, registered pad outputs and an atomic config load that tri-states remapped pins.
module io_map_sync #(
  parameter int PIN_NUM     = 24,
  parameter int CFG_NBIT    = 8,
  parameter int MIPI_GP_NUM = 4,
  parameter int FREQ_GP_NUM = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PIN_NUM*CFG_NBIT-1:0] i_cfg,
  input  logic                        i_cfg_vld,
  output logic                        o_cfg_busy,
  output logic                        o_cfg_done,
  output logic                        o_cfg_err,
  input  logic [PIN_NUM-1:0]          o_ioctrl_dir,
  input  logic [PIN_NUM-1:0]          o_ioctrl_db,
  output logic [PIN_NUM-1:0]          i_ioctrl_db,
  input  logic [MIPI_GP_NUM-1:0]      mipi_sclk,
  input  logic [MIPI_GP_NUM-1:0]      mipi_sdo,
  input  logic [MIPI_GP_NUM-1:0]      mipi_sdo_en,
  output logic [MIPI_GP_NUM-1:0]      mipi_sdi,
  output logic [FREQ_GP_NUM-1:0]      freq_io,
  input  logic [PIN_NUM-1:0]          i_io_db,
  output logic [PIN_NUM-1:0]          o_io_dir,
  output logic [PIN_NUM-1:0]          o_io_db
);
  localparam int SDA0 = 1 + MIPI_GP_NUM;
  localparam int FRQ0 = 'h19;
  localparam int CW = $clog2(TURN_CYCLES + 1);
  localparam logic [1:0] K_GPIO = 2'd0, K_SCLK = 2'd1, K_SDA = 2'd2, K_FRQ = 2'd3;
  typedef logic [PIN_NUM-1:0][CFG_NBIT-1:0] map_t;
  typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_t;
  state_t state, state_nxt;
  map_t cfg, active, shadow, eff;
  logic [PIN_NUM-1:0] chg, chg_new, mask_d, dir_d, db_d, sp;
  logic [SYNC_STAGES-1:0][PIN_NUM-1:0] sync;
  logic [CW-1:0] cnt;
  logic [MIPI_GP_NUM-1:0] seen_sclk, seen_sda;
  logic conflict;
  function automatic logic [1:0] kind_of(input logic [CFG_NBIT-1:0] c);
    int v;
    v = int'(c);
    return (v >= 1 && v < SDA0) ? K_SCLK :
           (v >= SDA0 && v < SDA0 + MIPI_GP_NUM) ? K_SDA :
           (v >= FRQ0 && v < FRQ0 + FREQ_GP_NUM) ? K_FRQ : K_GPIO;
  endfunction
  function automatic int grp_of(input logic [CFG_NBIT-1:0] c);
    int v;
    v = int'(c);
    return kind_of(c) == K_SCLK ? v - 1 : kind_of(c) == K_SDA ? v - SDA0 : v - FRQ0;
  endfunction
  assign cfg = i_cfg;
  assign o_cfg_busy = state != IDLE;
  assign o_cfg_done = state == APPLY;
  // Pad registers load the map that will be in force next cycle, so the tri-state
  // window lines up exactly with DRAIN+APPLY and the new map lands right after APPLY.
  always_comb begin
    chg_new = '0;
    for (int m = 0; m < PIN_NUM; m++) chg_new[m] = cfg[m] != active[m];
    state_nxt = state;
    if (state == IDLE && i_cfg_vld) state_nxt = |chg_new ? DRAIN : APPLY;
    if (state == DRAIN && cnt == '0) state_nxt = APPLY;
    if (state == APPLY) state_nxt = IDLE;
    mask_d = state == IDLE ? (i_cfg_vld ? chg_new : '0) : state == DRAIN ? chg : '0;
    eff = state == APPLY ? shadow : active;
  end
  always_comb begin
    dir_d = '0;
    db_d = '0;
    for (int m = 0; m < PIN_NUM; m++) begin
      if (kind_of(eff[m]) == K_GPIO) begin
        dir_d[m] = o_ioctrl_dir[m];
        db_d[m] = o_ioctrl_db[m];
      end
      for (int k = 0; k < MIPI_GP_NUM; k++) begin
        if (kind_of(eff[m]) == K_SCLK && grp_of(eff[m]) == k) begin
          dir_d[m] = 1'b1;
          db_d[m] = mipi_sclk[k];
        end
        if (kind_of(eff[m]) == K_SDA && grp_of(eff[m]) == k) begin
          dir_d[m] = mipi_sdo_en[k];
          db_d[m] = mipi_sdo[k];
        end
      end
    end
  end
  always_comb begin
    sp = sync[SYNC_STAGES-1] & ~chg;
    i_ioctrl_db = '0;
    mipi_sdi = '0;
    freq_io = '0;
    for (int m = 0; m < PIN_NUM; m++) begin
      i_ioctrl_db[m] = kind_of(active[m]) == K_GPIO && sp[m];
      for (int k = 0; k < MIPI_GP_NUM; k++)
        mipi_sdi[k] = mipi_sdi[k] | (kind_of(active[m]) == K_SDA && grp_of(active[m]) == k && sp[m]);
      for (int k = 0; k < FREQ_GP_NUM; k++)
        freq_io[k] = freq_io[k] | (kind_of(active[m]) == K_FRQ && grp_of(active[m]) == k && sp[m]);
    end
  end
  // Only SCLK/SDA groups may have a single driver; counter fan-in is legal.
  always_comb begin
    seen_sclk = '0;
    seen_sda = '0;
    conflict = 1'b0;
    for (int m = 0; m < PIN_NUM; m++) begin
      for (int k = 0; k < MIPI_GP_NUM; k++) begin
        if (kind_of(shadow[m]) == K_SCLK && grp_of(shadow[m]) == k) begin
          conflict = conflict | seen_sclk[k];
          seen_sclk[k] = 1'b1;
        end
        if (kind_of(shadow[m]) == K_SDA && grp_of(shadow[m]) == k) begin
          conflict = conflict | seen_sda[k];
          seen_sda[k] = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      active <= '0;
      shadow <= '0;
      chg <= '0;
      cnt <= '0;
      sync <= '0;
      o_cfg_err <= 1'b0;
      o_io_dir <= '0;
      o_io_db <= '0;
    end else begin
      state <= state_nxt;
      sync <= {sync[SYNC_STAGES-2:0], i_io_db};
      o_io_dir <= dir_d & ~mask_d;
      o_io_db <= db_d & ~mask_d;
      if (state == IDLE && i_cfg_vld) begin
        shadow <= cfg;
        chg <= chg_new;
        cnt <= CW'(TURN_CYCLES - 1);
      end
      if (state == DRAIN && cnt != '0) cnt <= cnt - CW'(1);
      if (state == APPLY) begin
        active <= shadow;
        chg <= '0;
        o_cfg_err <= conflict;
      end
    end
  end
endmodule

// File: tb/tb_io_map_sync.sv
// tb_io_map_sync: scoreboard bench for io_map_sync; expectations are queued per cycle
module tb_io_map_sync;
  localparam int PIN_NUM = 24, CFG_NBIT = 8, MIPI_GP_NUM = 4, FREQ_GP_NUM = 4;
  localparam int SYNC_STAGES = 2, TURN_CYCLES = 4;
  typedef logic [PIN_NUM-1:0][CFG_NBIT-1:0] map_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [PIN_NUM*CFG_NBIT-1:0] i_cfg = '0;
  logic i_cfg_vld = 1'b0;
  logic o_cfg_busy, o_cfg_done, o_cfg_err;
  logic [PIN_NUM-1:0] o_ioctrl_dir = '0, o_ioctrl_db = '0, i_io_db = '0;
  logic [PIN_NUM-1:0] i_ioctrl_db, o_io_dir, o_io_db;
  logic [MIPI_GP_NUM-1:0] mipi_sclk = '0, mipi_sdo = '0, mipi_sdo_en = '0, mipi_sdi;
  logic [FREQ_GP_NUM-1:0] freq_io;
  int cyc = 0, n_chk = 0, n_err = 0;
  int q_cyc[$], q_sig[$];
  logic [31:0] q_exp[$];
  string q_tag[$];
  map_t cur_map, c_a, c_b;
  logic cur_err;
  io_map_sync #(.PIN_NUM(PIN_NUM), .CFG_NBIT(CFG_NBIT), .MIPI_GP_NUM(MIPI_GP_NUM),
    .FREQ_GP_NUM(FREQ_GP_NUM), .SYNC_STAGES(SYNC_STAGES), .TURN_CYCLES(TURN_CYCLES)) dut (
    .clk(clk), .rst(rst), .i_cfg(i_cfg), .i_cfg_vld(i_cfg_vld), .o_cfg_busy(o_cfg_busy),
    .o_cfg_done(o_cfg_done), .o_cfg_err(o_cfg_err), .o_ioctrl_dir(o_ioctrl_dir),
    .o_ioctrl_db(o_ioctrl_db), .i_ioctrl_db(i_ioctrl_db), .mipi_sclk(mipi_sclk),
    .mipi_sdo(mipi_sdo), .mipi_sdo_en(mipi_sdo_en), .mipi_sdi(mipi_sdi), .freq_io(freq_io),
    .i_io_db(i_io_db), .o_io_dir(o_io_dir), .o_io_db(o_io_db));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [31:0] obs(input int s);
    return s == 0 ? {8'h0, o_io_dir} : s == 1 ? {8'h0, o_io_db} :
           s == 2 ? {i_ioctrl_db, mipi_sdi, freq_io} : {29'h0, o_cfg_err, o_cfg_done, o_cfg_busy};
  endfunction
  always @(negedge clk) begin
    for (int i = q_cyc.size() - 1; i >= 0; i--)
      if (q_cyc[i] == cyc) begin
        check(q_tag[i], obs(q_sig[i]), q_exp[i]);
        q_cyc.delete(i);
        q_sig.delete(i);
        q_exp.delete(i);
        q_tag.delete(i);
      end
  end
  task automatic push(input int dc, input int s, input logic [31:0] v, input string tag);
    q_cyc.push_back(cyc + dc);
    q_sig.push_back(s);
    q_exp.push_back(v);
    q_tag.push_back(tag);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rnd_in();
    o_ioctrl_dir = 24'($urandom);
    o_ioctrl_db = 24'($urandom);
    mipi_sclk = 4'($urandom);
    mipi_sdo = 4'($urandom);
    mipi_sdo_en = 4'($urandom);
  endtask
  // Reference pad model: codes 1..4 SCLK, 5..8 SDA, 25..28 counter, anything else GPIO.
  function automatic logic [47:0] m_pad(input map_t mp, input logic [PIN_NUM-1:0] mask);
    logic [PIN_NUM-1:0] d, b;
    int c;
    d = '0;
    b = '0;
    for (int m = 0; m < PIN_NUM; m++) begin
      c = int'(mp[m]);
      if (!mask[m]) begin
        if (c >= 1 && c <= 4) begin
          d[m] = 1'b1;
          b[m] = mipi_sclk[2'(c - 1)];
        end else if (c >= 5 && c <= 8) begin
          d[m] = mipi_sdo_en[2'(c - 5)];
          b[m] = mipi_sdo[2'(c - 5)];
        end else if (!(c >= 25 && c <= 28)) begin
          d[m] = o_ioctrl_dir[m];
          b[m] = o_ioctrl_db[m];
        end
      end
    end
    return {d, b};
  endfunction
  function automatic logic [31:0] m_in(input map_t mp, input logic [PIN_NUM-1:0] mask,
                                       input logic [PIN_NUM-1:0] pad);
    logic [PIN_NUM-1:0] g;
    logic [3:0] s, f;
    int c;
    g = '0;
    s = '0;
    f = '0;
    for (int m = 0; m < PIN_NUM; m++) begin
      c = int'(mp[m]);
      if (!mask[m] && pad[m]) begin
        if (c >= 5 && c <= 8) s[2'(c - 5)] = 1'b1;
        else if (c >= 25 && c <= 28) f[2'(c - 25)] = 1'b1;
        else if (!(c >= 1 && c <= 4)) g[m] = 1'b1;
      end
    end
    return {g, s, f};
  endfunction
  function automatic logic m_conf(input map_t mp);
    int n [1:8];
    int c;
    logic r;
    r = 1'b0;
    for (int k = 1; k <= 8; k++) n[k] = 0;
    for (int m = 0; m < PIN_NUM; m++) begin
      c = int'(mp[m]);
      if (c >= 1 && c <= 8) n[c]++;
    end
    for (int k = 1; k <= 8; k++) if (n[k] > 1) r = 1'b1;
    return r;
  endfunction
  function automatic logic [7:0] rnd_code();
    int s;
    s = int'($urandom_range(0, 5));
    return s == 0 ? 8'h00 : s == 1 ? 8'(1 + $urandom_range(0, 3)) : s == 2 ? 8'(5 + $urandom_range(0, 3)) :
           s == 3 ? 8'(25 + $urandom_range(0, 3)) : s == 4 ? 8'hFF : 8'($urandom);
  endfunction
  // Queue next-cycle expectations from the inputs driven now, then advance one cycle.
  task automatic cycle_chk(input map_t mp, input logic [PIN_NUM-1:0] mask, input logic [2:0] fl,
                           input string tag);
    logic [47:0] p;
    p = m_pad(mp, mask);
    push(1, 0, {8'h0, p[47:24]}, {tag, "_dir"});
    push(1, 1, {8'h0, p[23:0]}, {tag, "_db"});
    push(1, 2, m_in(mp, mask, i_io_db), {tag, "_in"});
    push(1, 3, {29'h0, fl}, {tag, "_flags"});
    tick(1);
    rnd_in();
  endtask
  task automatic in_chk(input logic [PIN_NUM-1:0] pad, input string tag);
    push(1, 2, m_in(cur_map, '0, i_io_db), {tag, "_old"});
    i_io_db = pad;
    push(SYNC_STAGES, 2, m_in(cur_map, '0, pad), {tag, "_new"});
    tick(SYNC_STAGES);
  endtask
  task automatic load(input map_t nw, input int extra, input map_t other, input string tag);
    logic [PIN_NUM-1:0] chg;
    logic ne;
    int n;
    for (int m = 0; m < PIN_NUM; m++) chg[m] = nw[m] != cur_map[m];
    n = |chg ? TURN_CYCLES + 1 : 1;
    ne = m_conf(nw);
    i_cfg = nw;
    i_cfg_vld = 1'b1;
    for (int i = 1; i <= n + 1; i++) begin
      cycle_chk(i <= n ? cur_map : nw, i <= n ? chg : '0, {i <= n ? cur_err : ne, i == n, i <= n}, tag);
      i_cfg_vld = i == extra;
      if (i == extra) i_cfg = other;
    end
    cycle_chk(nw, '0, {ne, 2'b00}, {tag, "_after"});
    cur_map = nw;
    cur_err = ne;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    cur_map = '0;
    cur_err = 1'b0;
    i_io_db = '1;
    rnd_in();
    tick(2);
    for (int s = 0; s < 4; s++) push(1, s, 32'h0, "reset");
    tick(1);
    rst = 1'b0;
    i_io_db = '0;
    tick(2);
    cycle_chk(cur_map, '0, 3'b000, "idle0");
    cycle_chk(cur_map, '0, 3'b000, "idle1");
    c_a = '0;
    c_a[0] = 8'h01;
    load(c_a, 0, '0, "t1_sclk");
    c_a[3] = 8'h06;
    load(c_a, 0, '0, "t2_sda");
    in_chk(24'h000008, "t2_sdi");
    in_chk(24'h000000, "t2_sdi_clr");
    load(c_a, 0, '0, "t3_same");
    c_a[4] = 8'h02;
    c_a[5] = 8'h02;
    load(c_a, 0, '0, "t4_conf");
    c_a[5] = 8'h00;
    load(c_a, 0, '0, "t4_clean");
    c_b = c_a;
    c_b[6] = 8'h19;
    c_b[11] = 8'h04;
    c_a[6] = 8'h07;
    load(c_a, 3, c_b, "t5_drop");
    c_b = cur_map;
    c_b[10] = 8'h03;
    i_cfg = c_b;
    i_cfg_vld = 1'b1;
    cycle_chk(cur_map, 24'h000400, {cur_err, 2'b01}, "t5_rst_d1");
    i_cfg_vld = 1'b0;
    cycle_chk(cur_map, 24'h000400, {cur_err, 2'b01}, "t5_rst_d2");
    rst = 1'b1;
    for (int s = 0; s < 4; s++) push(1, s, 32'h0, "t5_rst");
    tick(1);
    rst = 1'b0;
    cur_map = '0;
    cur_err = 1'b0;
    begin
      logic [47:0] p;
      p = m_pad(cur_map, '0);
      push(1, 0, {8'h0, p[47:24]}, "t5_rel_dir");
      push(1, 1, {8'h0, p[23:0]}, "t5_rel_db");
      push(1, 2, 32'h0, "t5_rel_in");
      push(1, 3, 32'h0, "t5_rel_flags");
    end
    tick(1);
    rnd_in();
    for (int i = 0; i < 3; i++) cycle_chk(cur_map, '0, 3'b000, "t5_nodone");
    c_a = '0;
    c_a[7] = 8'h1A;
    c_a[8] = 8'h1A;
    c_a[9] = 8'hFF;
    load(c_a, 0, '0, "t6_freq");
    in_chk(24'h000100, "t6_frq1");
    in_chk(24'h000200, "t6_gpio_ff");
    in_chk(24'h000380, "t6_mix");
    for (int r = 0; r < 5; r++) begin
      for (int m = 0; m < PIN_NUM; m++) c_a[m] = rnd_code();
      load(c_a, 0, '0, "rnd_load");
      in_chk(24'($urandom), "rnd_in");
      in_chk(24'($urandom), "rnd_in2");
    end
    tick(SYNC_STAGES + 2);
    check("sb_drained", 32'(q_cyc.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/io_map_sync.md
Name: io_map_sync

Overview:
Parametrised successor to the combinational IO mapper. Routes PIN_NUM physical pins to GPIO control, MIPI SCLK/SDA groups or frequency-counter inputs, one per-pin config code each. Adds synchronised input sampling, registered outputs, atomic config load with a handshake, and a tri-state turnaround on pins whose mapping changes. Sits between the USB command/config register block and the pad ring.

Parameters:
PIN_NUM, 24, number of mapped pins
CFG_NBIT, 8, config code width per pin
MIPI_GP_NUM, 4, MIPI groups (SCLK/SDA pairs)
FREQ_GP_NUM, 4, frequency-counter inputs
SYNC_STAGES, 2, input synchroniser depth (>=2)
TURN_CYCLES, 4, tri-state cycles on remapped pins (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
i_cfg  in  PIN_NUM*CFG_NBIT  new config; pin m code at bits [(m+1)*CFG_NBIT-1 : m*CFG_NBIT]
i_cfg_vld  in  1  load strobe, one cycle
o_cfg_busy  out  1  load in progress; further i_cfg_vld ignored
o_cfg_done  out  1  one-cycle pulse when new map is committed
o_cfg_err  out  1  committed map has an SCLK/SDA group driven by >1 pin; sticky until next commit
o_ioctrl_dir  in  PIN_NUM  GPIO-mode direction (1 = drive)
o_ioctrl_db  in  PIN_NUM  GPIO-mode output data
i_ioctrl_db  out  PIN_NUM  GPIO-mode synchronised input data
mipi_sclk  in  MIPI_GP_NUM  SCLK per group
mipi_sdo  in  MIPI_GP_NUM  SDA output data per group
mipi_sdo_en  in  MIPI_GP_NUM  SDA drive enable per group
mipi_sdi  out  MIPI_GP_NUM  SDA synchronised input per group
freq_io  out  FREQ_GP_NUM  synchronised counter inputs
i_io_db  in  PIN_NUM  pad input data (asynchronous)
o_io_dir  out  PIN_NUM  pad drive enable (1 = drive)
o_io_db  out  PIN_NUM  pad output data

Behaviour:
- Codes: 0x00 GPIO; 0x01+k SCLK group k; 0x01+MIPI_GP_NUM+k SDA group k; 0x19+k counter k. Any other code, or a group index >= its count, maps as GPIO.
- GPIO: o_io_dir/o_io_db = o_ioctrl_dir/db; i_ioctrl_db = synced pad. SCLK: dir=1, db=mipi_sclk[k]. SDA: dir=mipi_sdo_en[k], db=mipi_sdo[k], input feeds mipi_sdi[k]. Counter: dir=0, db=0, input feeds freq_io[k]. Non-selected contributions are 0; i_ioctrl_db[m]=0 when pin m is not GPIO.
- mipi_sdi[k], freq_io[k] = OR over all pins mapped to that group.
- Output path: o_io_dir/o_io_db registered, 1-cycle latency from source inputs.
- Input path: i_io_db passes through SYNC_STAGES flops, then combinational mux/OR; latency SYNC_STAGES cycles to i_ioctrl_db/mipi_sdi/freq_io.
- Reset: active map all GPIO; shadow cleared; sync flops 0; all outputs 0 (o_io_dir=0, so every pin is tri-stated); FSM IDLE.
- FSM IDLE: on i_cfg_vld capture i_cfg into shadow, chg = per-pin (shadow != active). If chg==0, go to APPLY; else go to DRAIN, cnt=TURN_CYCLES-1. o_cfg_busy=1 in all states except IDLE.
- DRAIN: for each pin with chg=1, o_io_dir=0 and o_io_db=0 and its input contributions are 0. Pins with chg=0 keep operating. The FSM decrements cnt and goes to APPLY when cnt reaches 0, so it stays in DRAIN exactly TURN_CYCLES cycles.
- APPLY (1 cycle): active <= shadow, o_cfg_done=1, o_cfg_err <= conflict(shadow), chg cleared, then IDLE. Changed pins stay tri-stated through APPLY. The new map appears on the pads the cycle after APPLY.
- Timing: vld at cycle T. With a change, DRAIN runs T+1..T+TURN_CYCLES, done at T+TURN_CYCLES+1. With no change, done at T+1.
- i_cfg_vld outside IDLE is dropped; there is no queueing.
- Conflict: two or more pins with a valid SCLK code for the same k, or a valid SDA code for the same k. Counter fan-in is not an error. A conflicting map is still applied.
- Reset mid-load: immediate return to IDLE with the all-GPIO map; the shadow is discarded; no done pulse.

Test Plan:
1. After reset, pulse i_cfg_vld with pin0=0x01, others 0, TURN_CYCLES=4. Pin0 o_io_dir=0 for 5 cycles, then o_io_db follows mipi_sclk[0] with dir=1. Done at T+5; pins 1..23 follow o_ioctrl_* throughout.
2. Pin3=0x06, mipi_sdo_en[1]=0, drive i_io_db[3]=1. mipi_sdi[1]=1 exactly SYNC_STAGES cycles later; mipi_sdi[0,2,3]=0; i_ioctrl_db[3]=0.
3. Reload an identical config: done at T+1, busy high 1 cycle, no pin is ever tri-stated.
4. Pins 4 and 5 both set to 0x02: map is applied and o_cfg_err=1. A subsequent clean load clears err at its done pulse.
5. Issue a second i_cfg_vld during DRAIN: it is ignored, and the final map equals the first config. Assert rst during DRAIN: next cycle all outputs are 0, busy=0, no done pulse.
6. Pins 7 and 8 set to 0x1A, pin8 input high: freq_io[1]=1, err=0. Code 0xFF on pin9: behaves as GPIO.
